// File: rtl/adder2_arb.sv
// Round-robin arbiter sharing one registered 2-bit adder among N_REQ requesters.
// Fixed IDLE -> BUSY -> DONE service cycle; one ack pulse per grant.

module adder2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [1:0] y
);
    assign y = a + b;
endmodule

module adder2_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] a_bus,
    input  logic [2*N_REQ-1:0] b_bus,
    output logic [N_REQ-1:0]   ack,
    output logic [1:0]         y,
    output logic [ID_W-1:0]    y_id,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, ptr_nxt, gnt_q, gnt_idx;
    logic [ID_W:0]   scan;
    logic [1:0]      a_q, b_q, sum;
    logic            found;

    adder2 u_add (.a(a_q), .b(b_q), .y(sum));

    // Scan upward from ptr with wrap; first hit wins. Works for non-power-of-two N_REQ.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(N_REQ))
                scan = scan - (ID_W+1)'(N_REQ);
            if (!found && req[scan[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[ID_W-1:0];
            end
        end
        ptr_nxt = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = BUSY;
            BUSY:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            gnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ack   <= '0;
            y     <= '0;
            y_id  <= '0;
            busy  <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: if (found) begin
                    // Operands are captured only here; later bus changes cannot disturb the add.
                    a_q   <= a_bus[{gnt_idx, 1'b0} +: 2];
                    b_q   <= b_bus[{gnt_idx, 1'b0} +: 2];
                    gnt_q <= gnt_idx;
                    ptr   <= ptr_nxt;
                end
                BUSY: begin
                    y    <= sum;
                    y_id <= gnt_q;
                    ack  <= N_REQ'(1) << gnt_q;
                end
                DONE:    ack <= '0;
                default: ack <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_adder2_arb.sv
// Directed self-checking bench for adder2_arb (N_REQ=4).

module tb_adder2_arb;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] a_bus = '0;
    logic [7:0] b_bus = '0;
    logic [3:0] ack;
    logic [1:0] y;
    logic [1:0] y_id;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc;

    adder2_arb #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .y(y), .y_id(y_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [1:0] a, input logic [1:0] b);
        a_bus[2*i +: 2] = a;
        b_bus[2*i +: 2] = b;
    endtask

    // Advance at least one cycle, then until ack appears (bounded).
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == 0 && n < 20);
        if (ack == 0) chk("ack_timeout", 32'(ack != 0), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_ack", ack, 0);
        chk("rst_y", y, 0);
        chk("rst_y_id", y_id, 0);
        chk("rst_busy", busy, 0);

        // Single request: 01+10 = 11
        set_ops(0, 2'b01, 2'b10);
        req = 4'b0001;
        tick();
        chk("s_busy_e0", busy, 1);
        chk("s_ack_e0", ack, 0);
        tick();
        chk("s_ack_e1", ack, 4'b0001);
        chk("s_y", y, 2'b11);
        chk("s_y_id", y_id, 0);
        chk("s_busy_e1", busy, 1);
        req = 4'b0000;
        tick();
        chk("s_ack_e2", ack, 0);
        chk("s_busy_e2", busy, 0);
        chk("s_y_hold", y, 2'b11);
        tick();
        chk("s_busy_e3", busy, 0);
        chk("s_ack_e3", ack, 0);

        // Wrap-around sum: 11+10 = 01, ptr -> 3
        set_ops(2, 2'b11, 2'b10);
        req = 4'b0100;
        wait_ack(cyc);
        chk("w_lat", cyc, 2);
        chk("w_ack", ack, 4'b0100);
        chk("w_y", y, 2'b01);
        chk("w_y_id", y_id, 2);
        req = 4'b0101;
        wait_ack(cyc);
        chk("w_first_gnt", ack, 4'b0001);
        chk("w_first_y", y, 2'b11);
        chk("w_first_sp", cyc, 3);
        req = 4'b0100;
        wait_ack(cyc);
        chk("w_second_gnt", ack, 4'b0100);
        chk("w_second_y", y, 2'b01);
        req = 4'b0000;
        repeat (2) tick();

        // Round robin, all four held: ai=i, bi=1
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 2'(i), 2'b01);
        req = 4'b1111;
        begin
            logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            logic [1:0] exp_y   [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
            for (int k = 0; k < 5; k++) begin
                wait_ack(cyc);
                chk($sformatf("rr_ack%0d", k), ack, exp_ack[k]);
                chk($sformatf("rr_y%0d", k), y, exp_y[k]);
                chk($sformatf("rr_sp%0d", k), cyc, (k == 0) ? 2 : 3);
            end
        end
        req = 4'b0000;
        repeat (2) tick();

        // Fairness: req0 greedy, req1 joins one cycle after first grant
        do_reset();
        set_ops(0, 2'b01, 2'b00);
        set_ops(1, 2'b10, 2'b01);
        req = 4'b0001;
        wait_ack(cyc);
        chk("f_g0", ack, 4'b0001);
        req = 4'b0011;
        wait_ack(cyc);
        chk("f_g1", ack, 4'b0010);
        chk("f_y1", y, 2'b11);
        chk("f_sp1", cyc, 3);
        req = 4'b0001;
        wait_ack(cyc);
        chk("f_g2", ack, 4'b0001);
        chk("f_y2", y, 2'b01);
        req = 4'b0000;
        repeat (2) tick();

        // Reset while BUSY aborts the transaction
        set_ops(3, 2'b01, 2'b01);
        req = 4'b1000;
        tick();
        chk("r_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_ack", ack, 0);
        chk("r_y", y, 0);
        chk("r_y_id", y_id, 0);
        chk("r_busy0", busy, 0);
        wait_ack(cyc);
        chk("r_lat", cyc, 2);
        chk("r_ack3", ack, 4'b1000);
        chk("r_y3", y, 2'b10);
        chk("r_y_id3", y_id, 3);
        req = 4'b0011;
        wait_ack(cyc);
        chk("r_ptr0", ack, 4'b0001);
        req = 4'b0010;
        wait_ack(cyc);
        chk("r_ptr1", ack, 4'b0010);
        req = 4'b0000;
        repeat (2) tick();

        // Exhaustive sums through requester 3
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                set_ops(3, 2'(a), 2'(b));
                req = 4'b1000;
                wait_ack(cyc);
                chk($sformatf("x_y_%0d_%0d", a, b), y, (a + b) % 4);
                chk($sformatf("x_id_%0d_%0d", a, b), y_id, 3);
                req = 4'b0000;
                tick();
            end
        end

        // Operands changed after the grant edge are ignored
        set_ops(3, 2'b01, 2'b10);
        req = 4'b1000;
        tick();
        set_ops(3, 2'b11, 2'b11);
        wait_ack(cyc);
        chk("m_ack", ack, 4'b1000);
        chk("m_y", y, 2'b11);
        req = 4'b0000;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
